// File: rtl/aes_key_schedule_engine.sv
// Word-serial AES-128/192/256 key expansion streaming rk0..rkNr over valid/ready.
// Optional AES_KEY_SCHEDULE_REPLAY_EN keeps the schedule for reverse replay.

module aes_sbox (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254, then the forward affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] v;
    t = a;
    v = 8'h01;
    for (int k = 1; k < 8; k++) begin
      t = gmul(t, t);
      v = gmul(v, t);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  logic [7:0] s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= 8'h00;
    else        s_q <= sbox(a_i);
  end

  assign s_o = s_q;

endmodule

module aes_key_schedule_engine #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk_data,
  output logic [3:0]          rk_idx,
  output logic                rk_last
`ifdef AES_KEY_SCHEDULE_REPLAY_EN
  ,
  input  logic                replay_req,
  output logic                replay_valid,
  output logic [127:0]        replay_data,
  output logic [3:0]          replay_idx
`endif
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam logic [5:0] LAST_W  = 6'(4 * (NR + 1) - 1);
  localparam logic [5:0] END_W   = 6'(4 * (NR + 1));
  localparam logic [2:0] POS_MAX = 3'(NK - 1);
  localparam logic [3:0] IDX_MAX = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CALC, S_SUBW, S_HOLD, S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [31:0]  w_q [NK];
  logic [31:0]  w_d [NK];
  logic [31:0]  grp_q [4];
  logic [31:0]  grp_d [4];
  logic [5:0]   cnt_q, cnt_d;
  logic [2:0]   pos_q, pos_d;
  logic [2:0]   gcnt_q, gcnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         rkv_q, rkv_d;
  logic [127:0] rkd_q, rkd_d;
  logic [3:0]   idx_q, idx_d;

  logic [31:0]  tmp, sb_in, sb_out, nw;
  logic         accept, xfer, out_free;
  logic         sub_word, prod, gdone, ld_en;

  assign accept   = start && (state_q == S_IDLE);
  assign xfer     = rkv_q && rk_ready;
  assign out_free = !rkv_q || rk_ready;
  assign tmp      = w_q[NK-1];
  assign sub_word = (pos_q == 3'd0) || (NK == 8 && pos_q == 3'd4);
  assign sb_in    = (pos_q == 3'd0) ? {tmp[23:0], tmp[31:24]} : tmp;
  assign prod     = (state_q == S_CALC && !sub_word) || (state_q == S_SUBW);
  assign gdone    = prod && (gcnt_q == 3'd3);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .clk   (clk),
      .rst_n (rst_n),
      .a_i   (sb_in[8*b +: 8]),
      .s_o   (sb_out[8*b +: 8])
    );
  end

  always_comb begin
    nw = w_q[0] ^ tmp;
    if (state_q == S_SUBW)
      nw = w_q[0] ^ sb_out ^ ((pos_q == 3'd0) ? {rcon_q, 24'h0} : 32'h0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: state_d = (NK == 8) ? S_HOLD : S_CALC;
      S_CALC, S_SUBW: begin
        if (state_q == S_CALC && sub_word) state_d = S_SUBW;
        else if (gdone && !out_free)       state_d = S_HOLD;
        else if (gdone && cnt_q == LAST_W) state_d = S_DONE;
        else                               state_d = S_CALC;
      end
      S_HOLD: if (out_free) state_d = (cnt_q == END_W) ? S_DONE : S_CALC;
      S_DONE: if (xfer) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Words collect in grp; a full group waits there while the output is busy.
  always_comb begin
    w_d    = w_q;
    grp_d  = grp_q;
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    gcnt_d = gcnt_q;
    rcon_d = rcon_q;
    rkd_d  = rkd_q;
    idx_d  = idx_q;
    rkv_d  = rkv_q && !rk_ready;
    ld_en  = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) begin
        for (int j = 0; j < NK; j++) w_d[j] = key_in[KEY_BITS-1-32*j -: 32];
        cnt_d  = 6'(NK);
        pos_d  = 3'd0;
        gcnt_d = 3'd0;
        rcon_d = 8'h01;
      end
      S_LOAD: begin
        ld_en = 1'b1;
        rkd_d = {w_q[0], w_q[1], w_q[2], w_q[3]};
        idx_d = 4'd0;
        for (int j = 4; j < NK; j++) grp_d[j-4] = w_q[j];
        gcnt_d = 3'(NK - 4);
      end
      S_CALC, S_SUBW: if (prod) begin
        for (int j = 0; j < NK - 1; j++) w_d[j] = w_q[j+1];
        w_d[NK-1] = nw;
        cnt_d = cnt_q + 6'd1;
        pos_d = (pos_q == POS_MAX) ? 3'd0 : pos_q + 3'd1;
        if (state_q == S_SUBW && pos_q == 3'd0)
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        grp_d[gcnt_q[1:0]] = nw;
        gcnt_d = gcnt_q + 3'd1;
        if (gdone && out_free) begin
          ld_en  = 1'b1;
          rkd_d  = {grp_q[0], grp_q[1], grp_q[2], nw};
          idx_d  = idx_q + 4'd1;
          gcnt_d = 3'd0;
        end
      end
      S_HOLD: if (out_free) begin
        ld_en  = 1'b1;
        rkd_d  = {grp_q[0], grp_q[1], grp_q[2], grp_q[3]};
        idx_d  = idx_q + 4'd1;
        gcnt_d = 3'd0;
      end
      default: ;
    endcase
    if (ld_en) rkv_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NK; j++) w_q[j] <= 32'h0;
      for (int j = 0; j < 4; j++) grp_q[j] <= 32'h0;
      cnt_q  <= 6'd0;
      pos_q  <= 3'd0;
      gcnt_q <= 3'd0;
      rcon_q <= 8'h00;
      rkv_q  <= 1'b0;
      rkd_q  <= 128'h0;
      idx_q  <= 4'd0;
    end else begin
      w_q    <= w_d;
      grp_q  <= grp_d;
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      gcnt_q <= gcnt_d;
      rcon_q <= rcon_d;
      rkv_q  <= rkv_d;
      rkd_q  <= rkd_d;
      idx_q  <= idx_d;
    end
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    rk_valid = rkv_q;
    rk_data  = rkd_q;
    rk_idx   = idx_q;
    rk_last  = rkv_q && (idx_q == IDX_MAX);
  end

`ifdef AES_KEY_SCHEDULE_REPLAY_EN
  logic [127:0] mem_q [NR+1];
  logic         stored_q, stored_d;
  logic         ract_q, ract_d;
  logic [3:0]   ridx_q, ridx_d;

  always_comb begin
    stored_d = stored_q;
    ract_d   = ract_q;
    ridx_d   = ridx_q;
    if (accept) begin
      stored_d = 1'b0;
      ract_d   = 1'b0;
    end else if (state_q == S_DONE && xfer) begin
      stored_d = 1'b1;
    end else if (ract_q) begin
      if (ridx_q == 4'd0) ract_d = 1'b0;
      else                ridx_d = ridx_q - 4'd1;
    end else if (replay_req && state_q == S_IDLE && stored_q) begin
      ract_d = 1'b1;
      ridx_d = IDX_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= NR; j++) mem_q[j] <= 128'h0;
      stored_q <= 1'b0;
      ract_q   <= 1'b0;
      ridx_q   <= 4'd0;
    end else begin
      if (ld_en) mem_q[idx_d] <= rkd_d;
      stored_q <= stored_d;
      ract_q   <= ract_d;
      ridx_q   <= ridx_d;
    end
  end

  assign replay_valid = ract_q;
  assign replay_data  = mem_q[ridx_q];
  assign replay_idx   = ridx_q;
`endif

endmodule

// File: tb/tb_aes_key_schedule_engine.sv
// Directed bench for aes_key_schedule_engine using FIPS-197 key expansion vectors.

module tb_aes_key_schedule_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         s1, s2, s3;
  logic [127:0] key1;
  logic [191:0] key2;
  logic [255:0] key3;
  logic         b1, b2, b3, v1, v2, v3, r1, r2, r3, l1, l2, l3;
  logic [127:0] d1, d2, d3;
  logic [3:0]   i1, i2, i3;
`ifdef AES_KEY_SCHEDULE_REPLAY_EN
  logic         q1, q2, q3, rv1, rv2, rv3;
  logic [127:0] rd1, rd2, rd3;
  logic [3:0]   ri1, ri2, ri3;
`endif

  int           tests = 0;
  int           fails = 0;
  int           got;
  logic         prev_hold;
  logic [127:0] prev_d;

  logic [127:0] exp128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_key_schedule_engine #(.KEY_BITS(128)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .key_in(key1), .busy(b1),
    .rk_valid(v1), .rk_ready(r1), .rk_data(d1), .rk_idx(i1), .rk_last(l1)
`ifdef AES_KEY_SCHEDULE_REPLAY_EN
    , .replay_req(q1), .replay_valid(rv1), .replay_data(rd1), .replay_idx(ri1)
`endif
  );

  aes_key_schedule_engine #(.KEY_BITS(192)) u2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .key_in(key2), .busy(b2),
    .rk_valid(v2), .rk_ready(r2), .rk_data(d2), .rk_idx(i2), .rk_last(l2)
`ifdef AES_KEY_SCHEDULE_REPLAY_EN
    , .replay_req(q2), .replay_valid(rv2), .replay_data(rd2), .replay_idx(ri2)
`endif
  );

  aes_key_schedule_engine #(.KEY_BITS(256)) u3 (
    .clk(clk), .rst_n(rst_n), .start(s3), .key_in(key3), .busy(b3),
    .rk_valid(v3), .rk_ready(r3), .rk_data(d3), .rk_idx(i3), .rk_last(l3)
`ifdef AES_KEY_SCHEDULE_REPLAY_EN
    , .replay_req(q3), .replay_valid(rv3), .replay_data(rd3), .replay_idx(ri3)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    r1 = 1'b1; r2 = 1'b1; r3 = 1'b1;
    key1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    key3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
`ifdef AES_KEY_SCHEDULE_REPLAY_EN
    q1 = 1'b0; q2 = 1'b0; q3 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(b1), 128'(0));
    chk("rst_valid", 128'(v1), 128'(0));
    chk("rst_data", d1, 128'(0));
    chk("rst_idx", 128'(i1), 128'(0));
    chk("rst_last", 128'(l1), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // AES-128 with rk_ready high: rk_k valid in cycle 5k+1
    s1 = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b0;
    chk("t1_busy", 128'(b1), 128'(1));
    for (int n = 1; n <= 51; n++) begin
      @(posedge clk); #1;
      chk("t1_valid", 128'(v1), 128'(n % 5 == 1));
      if (n % 5 == 1) begin
        chk("t1_data", d1, exp128[n/5]);
        chk("t1_idx", 128'(i1), 128'(n / 5));
      end
    end
    chk("t1_last", 128'(l1), 128'(1));
    @(posedge clk); #1;
    chk("t1_busy_end", 128'(b1), 128'(0));
    chk("t1_valid_end", 128'(v1), 128'(0));

`ifdef AES_KEY_SCHEDULE_REPLAY_EN
    q1 = 1'b1;
    @(posedge clk); #1;
    q1 = 1'b0;
    for (int j = 0; j < 11; j++) begin
      chk("rp_valid", 128'(rv1), 128'(1));
      chk("rp_data", rd1, exp128[10-j]);
      chk("rp_idx", 128'(ri1), 128'(10 - j));
      @(posedge clk); #1;
    end
    chk("rp_valid_end", 128'(rv1), 128'(0));
`endif

    // AES-192
    s2 = 1'b1;
    @(posedge clk); #1;
    s2 = 1'b0;
    got = 0;
    for (int n = 0; n < 300 && got < 13; n++) begin
      if (v2) begin
        chk("t2_idx", 128'(i2), 128'(got));
        chk("t2_last", 128'(l2), 128'(got == 12));
        if (got == 0) chk("t2_rk0", d2, key2[191:64]);
        if (got == 1) chk("t2_rk1", d2, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        if (got == 12) chk("t2_rk12", d2, 128'he98ba06f448c773c8ecc720401002202);
        got++;
      end
      @(posedge clk); #1;
    end
    chk("t2_count", 128'(got), 128'(13));
    chk("t2_busy_end", 128'(b2), 128'(0));

    // AES-256
    s3 = 1'b1;
    @(posedge clk); #1;
    s3 = 1'b0;
    got = 0;
    for (int n = 0; n < 300 && got < 15; n++) begin
      if (v3) begin
        chk("t3_idx", 128'(i3), 128'(got));
        chk("t3_last", 128'(l3), 128'(got == 14));
        if (got == 0) chk("t3_rk0", d3, key3[255:128]);
        if (got == 1) chk("t3_rk1", d3, key3[127:0]);
        if (got == 2) chk("t3_rk2", d3, 128'h9ba354118e6925afa51a8b5f2067fcde);
        if (got == 14) chk("t3_rk14", d3, 128'hfe4890d1e6188d0b046df344706c631e);
        got++;
      end
      @(posedge clk); #1;
    end
    chk("t3_count", 128'(got), 128'(15));
    chk("t3_busy_end", 128'(b3), 128'(0));

    // AES-128 with random backpressure
    s1 = 1'b1;
    r1 = 1'b0;
    @(posedge clk); #1;
    s1 = 1'b0;
    got = 0;
    prev_hold = 1'b0;
    prev_d = '0;
    for (int n = 0; n < 3000 && got < 11; n++) begin
      if (prev_hold) begin
        chk("bp_hold_valid", 128'(v1), 128'(1));
        chk("bp_hold_data", d1, prev_d);
      end
      r1 = 1'($urandom_range(0, 1));
      if (v1 && r1) begin
        chk("bp_data", d1, exp128[got]);
        chk("bp_idx", 128'(i1), 128'(got));
        got++;
      end
      prev_hold = v1 && !r1;
      prev_d = d1;
      @(posedge clk); #1;
    end
    chk("bp_count", 128'(got), 128'(11));
    chk("bp_busy_end", 128'(b1), 128'(0));
    chk("bp_valid_end", 128'(v1), 128'(0));
    r1 = 1'b1;

    // start while busy ignored, then async reset mid-expansion
    s1 = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    s1 = 1'b1;
    key1 = '0;
    @(posedge clk); #1;
    s1 = 1'b0;
    key1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    chk("cc_busy", 128'(b1), 128'(1));
    chk("cc_valid21", 128'(v1), 128'(1));
    chk("cc_data21", d1, exp128[4]);
    chk("cc_idx21", 128'(i1), 128'(4));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("cc_rst_busy", 128'(b1), 128'(0));
    chk("cc_rst_valid", 128'(v1), 128'(0));
    chk("cc_rst_data", d1, 128'(0));
    chk("cc_rst_idx", 128'(i1), 128'(0));
    chk("cc_rst_last", 128'(l1), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b0;
    got = 0;
    for (int n = 0; n < 200 && got < 11; n++) begin
      if (v1) begin
        chk("cc_data", d1, exp128[got]);
        chk("cc_idx", 128'(i1), 128'(got));
        got++;
      end
      @(posedge clk); #1;
    end
    chk("cc_count", 128'(got), 128'(11));
    chk("cc_busy_end", 128'(b1), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
